// File: rtl/dlsc_pcie_s6_tx_arb.sv
// Packet-granular round-robin arbiter in front of the Spartan-6 PCIe TLP
// transmit interface. One source owns the output from its first beat until
// its last beat is accepted, so TLPs never interleave. The output beat is
// registered with a single-stage skid-free register that supports 1 beat/cycle.
module dlsc_pcie_s6_tx_arb #(
  parameter int SOURCES  = 3,
  parameter int SRC_BITS = 2,
  parameter int BUF_MIN  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [SOURCES-1:0]      in_ready,
  input  logic [SOURCES-1:0]      in_valid,
  input  logic [SOURCES*32-1:0]   in_data,
  input  logic [SOURCES-1:0]      in_last,
  input  logic [SOURCES-1:0]      in_allow,
  input  logic [5:0]              tx_buf_av,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [31:0]             tx_data,
  output logic                    tx_last,
  output logic [SRC_BITS-1:0]     tx_src,
  output logic                    idle
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

  localparam logic [5:0]        BUF_MIN_L = 6'(BUF_MIN);
  localparam logic [SRC_BITS:0] SRC_CNT   = (SRC_BITS+1)'(SOURCES);

  logic [0:0]          state_q, state_d;
  logic [SRC_BITS-1:0] grant_q, grant_d;
  logic [SRC_BITS-1:0] last_grant_q, last_grant_d;
  logic                tx_valid_q, tx_valid_d;
  logic [31:0]         tx_data_q, tx_data_d;
  logic                tx_last_q, tx_last_d;
  logic [SRC_BITS-1:0] tx_src_q, tx_src_d;

  logic [SOURCES-1:0]  req;
  logic                arb_hit;
  logic [SRC_BITS-1:0] arb_sel;
  logic                buf_ok;
  logic                out_free;
  logic                pkt_active;
  logic                accept;
  logic [31:0]         src_data [SOURCES];

  // Slice the flat data bus into one word per source.
  for (genvar gi = 0; gi < SOURCES; gi++) begin : g_src
    assign src_data[gi] = in_data[32*gi +: 32];
    assign in_ready[gi] = pkt_active && out_free && (grant_q == SRC_BITS'(gi));
  end

  assign req        = in_valid & in_allow;
  assign buf_ok     = (tx_buf_av >= BUF_MIN_L);
  assign out_free   = !tx_valid_q || tx_ready;
  assign pkt_active = (state_q == ST_PKT);
  assign accept     = pkt_active && out_free && in_valid[grant_q];

  // Round-robin pick: first requester strictly after last_grant, wrapping.
  always_comb begin
    logic [SRC_BITS:0] cand;
    arb_hit = 1'b0;
    arb_sel = '0;
    cand    = '0;
    for (int k = 1; k <= SOURCES; k++) begin
      cand = {1'b0, last_grant_q} + (SRC_BITS+1)'(k);
      if (cand >= SRC_CNT) begin
        cand = cand - SRC_CNT;
      end
      if (!arb_hit && req[cand[SRC_BITS-1:0]]) begin
        arb_hit = 1'b1;
        arb_sel = cand[SRC_BITS-1:0];
      end
    end
  end

  // Grant FSM: arbitrate in idle, hold the grant until the last beat is taken.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_hit && buf_ok) begin
          grant_d = arb_sel;
          state_d = ST_PKT;
        end
      end
      default: begin
        if (accept && in_last[grant_q]) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end
      end
    endcase
  end

  // Output register: load on accept, drain on tx_ready, otherwise hold.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    tx_src_d   = tx_src_q;
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = src_data[grant_q];
      tx_last_d  = in_last[grant_q];
      tx_src_d   = grant_q;
    end else if (tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_BITS'(SOURCES-1);
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_last_q    <= 1'b0;
      tx_src_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      tx_last_q    <= tx_last_d;
      tx_src_q     <= tx_src_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_last  = tx_last_q;
  assign tx_src   = tx_src_q;
  assign idle     = (state_q == ST_IDLE) && !tx_valid_q;

endmodule

// File: tb/tb_dlsc_pcie_s6_tx_arb.sv
// Scoreboard bench for the TLP transmit arbiter. Sources are backlogged
// queues of packets; the reference model lays packets out in round-robin
// order over the permitted sources and the monitor checks every output beat.
module tb_dlsc_pcie_s6_tx_arb;
  localparam int N  = 3;
  localparam int SB = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      in_ready, in_valid, in_last, in_allow;
  logic [N*32-1:0]   in_data;
  logic [5:0]        tx_buf_av;
  logic              tx_ready, tx_valid, tx_last, idle;
  logic [31:0]       tx_data;
  logic [SB-1:0]     tx_src;

  always #5 clk = ~clk;

  dlsc_pcie_s6_tx_arb #(.SOURCES(N), .SRC_BITS(SB), .BUF_MIN(1)) dut (
    .clk(clk), .rst(rst), .in_ready(in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_allow(in_allow),
    .tx_buf_av(tx_buf_av), .tx_ready(tx_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_last(tx_last), .tx_src(tx_src), .idle(idle)
  );

  typedef struct packed {
    logic [31:0]   data;
    logic          last;
    logic [SB-1:0] src;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        src_q[N][$];
  int           errors = 0;
  int           checks = 0;
  logic [N-1:0] allow_v = '1;
  logic [N-1:0] dummy_v = '0;
  logic [5:0]   buf_v = 6'd1;
  bit           buf_rand = 0;
  int           ready_mode = 0;   // 0: always ready, 1: random, 2: toggling
  int           ready_pct = 70;
  int           gap_pct = 0;
  logic [N-1:0] fire = '0;
  logic [N-1:0] mid = '0;
  bit           mon_en = 1;
  int           model_last = N - 1;
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic add_pkt(int s, int len, logic [31:0] base, bit expect_it);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = base + 32'(i);
      b.last = (i == len - 1);
      b.src  = SB'(s);
      src_q[s].push_back(b);
      if (expect_it) exp_q.push_back(b);
    end
  endtask

  // Reference model: with every permitted source backlogged, grants rotate
  // through the permitted set starting after the previous winner.
  task automatic issue_rr(int rounds, int lmin, int lmax, logic [N-1:0] mask);
    int start;
    int s;
    for (int r = 0; r < rounds; r++) begin
      start = model_last;
      for (int k = 1; k <= N; k++) begin
        s = (start + k) % N;
        if (mask[s]) begin
          add_pkt(s, $urandom_range(lmin, lmax), $urandom & 32'hFFFF_FF00, 1);
          model_last = s;
        end
      end
    end
  endtask

  function automatic bit srcs_empty();
    bit e = 1;
    for (int s = 0; s < N; s++) if (src_q[s].size() != 0) e = 0;
    return e;
  endfunction

  task automatic wait_drain(string name, int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && srcs_empty() && idle) && n < budget);
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: drain timeout, got exp_left=%0d expected 0", name, exp_q.size());
    end
  endtask

  // Source/sink driver: inputs change 1 time unit after the clock edge.
  initial begin
    logic [31:0] d;
    logic        v, l;
    in_valid = '0; in_data = '0; in_last = '0; in_allow = '0;
    tx_buf_av = 6'd0; tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      fire = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) begin
        if (fire[s] && src_q[s].size() > 0) begin
          mid[s] = !src_q[s][0].last;
          void'(src_q[s].pop_front());
        end
      end
      for (int s = 0; s < N; s++) begin
        v = 0; d = '0; l = 0;
        if (src_q[s].size() > 0) begin
          if (!(mid[s] && $urandom_range(0, 99) < gap_pct)) begin
            v = 1; d = src_q[s][0].data; l = src_q[s][0].last;
          end
        end else if (dummy_v[s]) begin
          v = 1; d = 32'hDEAD_0000 | 32'(s); l = 1;
        end
        in_valid[s] = v;
        in_data[s*32 +: 32] = d;
        in_last[s] = l;
      end
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(0, 99) < ready_pct);
        default: tx_ready = cyc[0];
      endcase
      in_allow  = allow_v;
      tx_buf_av = buf_rand ? 6'($urandom_range(0, 3)) : buf_v;
    end
  end

  // Monitor: scoreboard pop per transferred beat, plus hold-while-stalled.
  initial begin
    beat_t         e;
    bit            prev_stall = 0;
    logic [31:0]   pd = '0;
    logic          pl = 1'b0;
    logic [SB-1:0] ps = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!tx_valid || tx_data !== pd || tx_last !== pl || tx_src !== ps) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b d=%h l=%0b s=%0d expected v=1 d=%h l=%0b s=%0d",
                     tx_valid, tx_data, tx_last, tx_src, pd, pl, ps);
          end
        end
        if (tx_valid && tx_ready && mon_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got src=%0d data=%h expected no beat", tx_src, tx_data);
          end else begin
            e = exp_q.pop_front();
            $display("beat src=%0d data=%08h last=%0b", tx_src, tx_data, tx_last);
            if (tx_data !== e.data || tx_last !== e.last || tx_src !== e.src) begin
              errors++;
              $display("FAIL beat: got src=%0d data=%h last=%0b expected src=%0d data=%h last=%0b",
                       tx_src, tx_data, tx_last, e.src, e.data, e.last);
            end
          end
        end
        prev_stall = tx_valid && !tx_ready;
        pd = tx_data; pl = tx_last; ps = tx_src;
      end
    end
  end

  // Watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ir, ir_cnt, first_tx, tx_cnt, idle_at, cnt;
    logic [N-1:0] mask;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_last", 32'(tx_last), 0);
    chk("rst_tx_src", 32'(tx_src), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_idle", 32'(idle), 1);
    @(posedge clk); #1 rst = 1'b0;

    // Single source 1, 3-beat TLP, cycle-accurate timing
    @(negedge clk);
    add_pkt(1, 3, 32'hA0, 1);
    model_last = 1;
    first_ir = -1; ir_cnt = 0; first_tx = -1; tx_cnt = 0; idle_at = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (in_ready[1]) begin if (first_ir < 0) first_ir = n; ir_cnt++; end
      if (tx_valid) begin if (first_tx < 0) first_tx = n; tx_cnt++; end
      if (first_tx > 0 && idle && idle_at < 0) idle_at = n;
    end
    chk("single_first_ready", 32'(first_ir), 2);
    chk("single_ready_cycles", 32'(ir_cnt), 3);
    chk("single_first_tx", 32'(first_tx), 3);
    chk("single_tx_cycles", 32'(tx_cnt), 3);
    chk("single_idle_return", 32'(idle_at), 6);
    wait_drain("single", 200);

    // Round-robin, all sources backlogged with 2-beat TLPs
    @(negedge clk);
    issue_rr(2, 2, 2, 3'b111);
    wait_drain("round_robin", 400);

    // Backpressure, tx_ready toggling during a 4-beat TLP
    ready_mode = 2;
    @(negedge clk);
    issue_rr(1, 4, 4, 3'b001);
    wait_drain("backpressure", 200);
    ready_mode = 0;

    // Start-permission gating
    @(negedge clk);
    allow_v = 3'b011;
    add_pkt(2, 6, 32'h0000_2000, 0);
    issue_rr(1, 3, 3, 3'b001);
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin @(negedge clk); cnt++; end
    repeat (5) @(negedge clk);
    chk("gate_src2_held", 32'(src_q[2].size()), 6);
    chk("gate_idle", 32'(idle), 1);
    for (int i = 0; i < src_q[2].size(); i++) exp_q.push_back(src_q[2][i]);
    model_last = 2;
    allow_v = 3'b111;
    cnt = 0;
    while (!in_ready[2] && cnt < 50) begin @(negedge clk); cnt++; end
    chk("gate_src2_granted", 32'(in_ready[2]), 1);
    allow_v = 3'b011;
    wait_drain("gate", 200);
    allow_v = 3'b111;

    // Buffer-space gating
    @(negedge clk);
    buf_v = 6'd0;
    issue_rr(1, 2, 2, 3'b111);
    repeat (8) @(negedge clk);
    chk("buf_block_idle", 32'(idle), 1);
    chk("buf_block_ready", 32'(in_ready), 0);
    chk("buf_block_valid", 32'(tx_valid), 0);
    buf_v = 6'd1;
    @(negedge clk);
    chk("buf_arb_bubble", 32'(in_ready), 0);
    @(negedge clk);
    chk("buf_src0_first", 32'(in_ready), 32'h1);
    wait_drain("buffer", 300);

    // Reset in the middle of a 4-beat TLP
    mon_en = 0;
    @(negedge clk);
    add_pkt(0, 4, 32'h0000_3000, 0);
    cnt = 0;
    for (int n = 0; n < 20 && cnt < 2; n++) begin
      @(negedge clk);
      if (in_valid[0] && in_ready[0]) cnt++;
    end
    chk("rst_mid_beats", 32'(cnt), 2);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    for (int s = 0; s < N; s++) src_q[s].delete();
    exp_q.delete();
    mid = '0;
    @(negedge clk);
    chk("rst_mid_tx_valid", 32'(tx_valid), 0);
    chk("rst_mid_in_ready", 32'(in_ready), 0);
    chk("rst_mid_idle", 32'(idle), 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    mon_en = 1;
    model_last = N - 1;
    issue_rr(1, 2, 3, 3'b111);
    wait_drain("after_reset", 300);

    // Randomized phases: random permitted set, gated dummy requesters,
    // random backpressure, mid-packet gaps and buffer starvation
    ready_mode = 1; gap_pct = 20; buf_rand = 1;
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      mask = N'($urandom_range(1, (1 << N) - 1));
      allow_v = mask;
      dummy_v = ~mask & N'($urandom);
      issue_rr(4, 1, 5, mask);
      wait_drain("random", 4000);
      dummy_v = '0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dlsc_pcie_s6_tx_arb.md
Name: dlsc_pcie_s6_tx_arb

Overview:
Packet-granular round-robin arbiter that shares the single Spartan-6 PCIe TLP transmit stream between several TLP generators: the inbound-path completion generator, the outbound-path write generator and the outbound-path read generator. It grants one source at a time and holds that grant until the source's last beat is accepted, so TLPs are never interleaved. A new packet starts only when core transmit buffer space is available. Output is registered; the block sits directly in front of the core trn_t* interface.

Parameters:
SOURCES, 3, number of requesting TLP sources (2..8); index 0 is the completion source.
SRC_BITS, 2, width of the source index; must satisfy 2**SRC_BITS >= SOURCES.
BUF_MIN, 1, minimum tx_buf_av value required to start a new packet.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_ready  out  SOURCES  per-source beat accept
in_valid  in  SOURCES  per-source beat valid
in_data  in  SOURCES*32  per-source beat data; source i occupies bits [32*i+31:32*i]
in_last  in  SOURCES  per-source last beat of TLP
in_allow  in  SOURCES  per-source start permission (e.g. non-posted credit OK); sampled only at arbitration
tx_buf_av  in  6  core transmit buffers available
tx_ready  in  1  core accepts output beat
tx_valid  out  1  output beat valid
tx_data  out  32  output beat data
tx_last  out  1  output last beat
tx_src  out  SRC_BITS  source index of the current output beat
idle  out  1  high when no packet is granted and the output register is empty

Behaviour:
- Reset values: tx_valid=0, tx_data=0, tx_last=0, tx_src=0, in_ready=0, state=ST_IDLE, last_grant=SOURCES-1 (source 0 wins first), idle=1.
- States:
  - ST_IDLE: compute req = in_valid & in_allow.
    - If req != 0 and tx_buf_av >= BUF_MIN: choose the first set bit of req strictly after last_grant, wrapping modulo SOURCES. Register it as grant and move to ST_PKT.
    - No beat is accepted in the arbitration cycle, so there is exactly one bubble per packet at the input.
  - ST_PKT: in_ready[grant] = (!tx_valid || tx_ready). All other in_ready bits are 0.
    - Each accepted beat loads tx_data, tx_last and tx_src=grant, and sets tx_valid the next cycle.
    - When an accepted beat has in_last=1: next state is ST_IDLE and last_grant<=grant.
- Output register:
  - tx_valid clears when tx_ready=1 and no new beat is loaded that cycle.
  - Load and drain in the same cycle are allowed, giving full throughput of 1 beat/cycle within a packet.
  - Latency from input accept to tx_valid is 1 cycle.
  - tx_data, tx_last and tx_src hold their value while tx_valid=1 and tx_ready=0.
- Arbitration may occur while the previous packet's last beat is still waiting in the output register; the output register is not part of arbitration.
- in_allow and tx_buf_av are examined only in ST_IDLE. Changes in either during ST_PKT have no effect on the current packet.
- Single-beat packets (in_valid and in_last in the first beat) are legal: ST_PKT lasts 1 cycle when tx_ready permits.
- A granted source that drops in_valid mid-packet keeps the grant indefinitely; in_ready remains asserted per the rule above.
- A source whose in_allow=0 is skipped; the round-robin pointer does not advance past it.
- tx_buf_av < BUF_MIN blocks all sources, including source 0.
- idle = (state==ST_IDLE) && !tx_valid.
- Reset mid-packet: the packet is abandoned and the output is cleared at once. Upstream sources are reset by the same rst.

Test Plan:
- Single source: source 1 sends a 3-beat TLP (0xA0,0xA1,0xA2 last) with tx_ready=1 -> in_ready[1] high cycles 2-4, tx beats on cycles 3-5 with tx_src=1 and tx_last only on 0xA2; idle returns to 1 on cycle 6.
- Round-robin: all 3 sources continuously valid with 2-beat TLPs -> grant order 0,1,2,0,1,2; no interleaving within a TLP; tx_last on every second beat.
- Backpressure: tx_ready toggled 1010 during a 4-beat TLP -> no beat lost or duplicated; tx_data stable while stalled; throughput 1 beat per 2 cycles.
- Gating: source 2 valid with in_allow[2]=0 and source 0 valid -> only source 0 granted; raising in_allow[2] gives source 2 the next grant. Deasserting in_allow[2] mid-packet does not stop that packet.
- Buffer gating: tx_buf_av=0 with all sources valid -> no grant and idle=1; setting tx_buf_av=1 starts source 0 on the next cycle.
- Reset mid-packet: assert rst after beat 2 of a 4-beat TLP -> tx_valid=0, in_ready=0 the next cycle; after release, source 0 wins first.
